fsqrt_arbiter: RTL and testbench

FSQRT_ARBITER -- requirements
Module: fsqrt_arbiter

---
 rtl/fsqrt_arbiter.sv | 144 ++++++++++++++
 tb/tb_fsqrt_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsqrt_arbiter.sv
// Round-robin arbiter sharing one fsqrt unit among NREQ requesters, with
// zero-operand bypass, per-requester result slots and a sticky timeout abort.
module fsqrt_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_x,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  output logic [32*NREQ-1:0]   resp_y,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [31:0]          fu_x,
  output logic                 fu_en,
  input  logic [31:0]          fu_y,
  input  logic                 fu_valid,
  input  logic                 fu_idle,
  output logic                 err
);

  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW   = $clog2(TIMEOUT + 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr, ptr_nxt, tag, win;
  logic [PW:0]       sum, sum_inc;
  logic [CW-1:0]     cnt;
  logic [NREQ-1:0]   zero, cand, win_oh, tag_oh, byp_wr, fu_wr;
  logic [2*NREQ-1:0] cand_rot, zero_rot;
  logic              found, win_zero, accept, start, bypass, fu_done, timeout;
  logic [31:0]       win_x;

  // Candidates: eligible requesters; only zero operands unless the unit can start now
  always_comb begin
    zero   = '0;
    cand   = '0;
    tag_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      zero[i]   = (req_x[32*i +: 31] == 31'd0);
      tag_oh[i] = (tag == PW'(i));
      cand[i]   = req_valid[i] && (!resp_valid[i] || resp_ready[i])
                  && !(state == WAIT && tag == PW'(i))
                  && (zero[i] || (state == IDLE && fu_idle));
    end
  end

  // Round-robin search starting at ptr
  always_comb begin
    cand_rot = {cand, cand} >> ptr;
    zero_rot = {zero, zero} >> ptr;
    found    = 1'b0;
    win_zero = 1'b0;
    win      = '0;
    sum      = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && cand_rot[k]) begin
        found    = 1'b1;
        win_zero = zero_rot[k];
        sum      = {1'b0, ptr} + (PW+1)'(k);
        if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
        win      = sum[PW-1:0];
      end
    end
    sum_inc = {1'b0, win} + (PW+1)'(1);
    if (sum_inc >= (PW+1)'(NREQ)) sum_inc = sum_inc - (PW+1)'(NREQ);
    ptr_nxt = sum_inc[PW-1:0];
    win_oh  = '0;
    win_x   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == PW'(i)) begin
        win_oh[i] = 1'b1;
        win_x     = req_x[32*i +: 32];
      end
    end
  end

  assign accept  = rstn && found;
  assign bypass  = accept && win_zero;
  assign start   = accept && !win_zero;
  assign fu_done = (state == WAIT) && fu_valid;
  assign timeout = (state == WAIT) && !fu_valid && (cnt == CW'(TIMEOUT - 1));
  assign byp_wr  = bypass ? win_oh : '0;
  assign fu_wr   = (fu_done || timeout) ? tag_oh : '0;

  // Next state and combinational handshake outputs
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    fu_en     = 1'b0;
    fu_x      = win_x;
    if (accept) req_ready = win_oh;
    case (state)
      IDLE: if (start) begin
        fu_en     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (fu_done || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Pointer, tag, wait counter, result slots and error flag
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr        <= '0;
      tag        <= '0;
      cnt        <= '0;
      resp_valid <= '0;
      resp_y     <= '0;
      err        <= 1'b0;
    end else begin
      if (accept) ptr <= ptr_nxt;
      if (start) begin
        tag <= win;
        cnt <= '0;
      end else if (state == WAIT && !fu_valid) begin
        cnt <= cnt + CW'(1);
      end
      if (timeout) err <= 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (byp_wr[i]) begin
          resp_valid[i]      <= 1'b1;
          resp_y[32*i +: 32] <= req_x[32*i +: 32];
        end else if (fu_wr[i]) begin
          resp_valid[i]      <= 1'b1;
          resp_y[32*i +: 32] <= fu_done ? fu_y : QNAN;
        end else if (resp_ready[i]) begin
          resp_valid[i]      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fsqrt_arbiter.sv
// Self-checking bench for fsqrt_arbiter: fsqrt stub with 3-cycle latency,
// per-requester scoreboard, vector table and hand-written corner sequences.
module tb_fsqrt_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [31:0] x0, x1;
  logic [63:0] req_x, resp_y;
  logic [31:0] fu_x, fu_y;
  logic        fu_en, fu_valid, fu_idle, err;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;

  assign req_x = {x1, x0};

  fsqrt_arbiter #(.NREQ(2), .TIMEOUT(15)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_x(req_x),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_y(resp_y),
    .resp_ready(resp_ready), .fu_x(fu_x), .fu_en(fu_en), .fu_y(fu_y),
    .fu_valid(fu_valid), .fu_idle(fu_idle), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sqrt_lut(input logic [31:0] x);
    case (x)
      32'h4080_0000: return 32'h4000_0000;
      32'h4110_0000: return 32'h4040_0000;
      32'h3F80_0000: return 32'h3F80_0000;
      32'h4180_0000: return 32'h4080_0000;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  // fsqrt unit stub: fu_valid three cycles after fu_en unless held off
  logic       busy = 1'b0;
  logic [1:0] cd = 2'd0;
  logic       hold = 1'b0;
  initial begin fu_valid = 1'b0; fu_y = '0; end
  assign fu_idle = !busy;
  always @(posedge clk) begin
    fu_valid <= 1'b0;
    if (fu_en) begin
      busy <= 1'b1;
      cd   <= 2'd1;
      fu_y <= sqrt_lut(fu_x);
    end else if (busy) begin
      if (cd == 2'd0) begin
        busy     <= 1'b0;
        fu_valid <= !hold;
      end else begin
        cd <= cd - 2'd1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] slot(input bit r);
    return r ? resp_y[63:32] : resp_y[31:0];
  endfunction

  function automatic logic [31:0] exp_of(input logic [31:0] x);
    if (x[30:0] == 31'd0) return x;
    if (hold) return 32'h7FC0_0000;
    return sqrt_lut(x);
  endfunction

  // Scoreboard: push on accept, pop on each newly presented response
  logic [31:0] sbq [2][$];
  bit          pend [2];
  bit          g_req [$];
  int unsigned g_cyc [$];

  task automatic mon_one(input bit r);
    logic [31:0] e;
    if (req_ready[r]) sbq[r].push_back(exp_of(r ? x1 : x0));
    if (resp_valid[r] && !pend[r]) begin
      if (sbq[r].size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected req=%0d actual=%h required=none", r, slot(r));
      end else begin
        e = sbq[r].pop_front();
        chk(r ? "sb_resp1" : "sb_resp0", slot(r), e);
      end
    end
    pend[r] = resp_valid[r] && !resp_ready[r];
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      sbq[0].delete();
      sbq[1].delete();
      pend[0] = 1'b0;
      pend[1] = 1'b0;
    end else begin
      mon_one(1'b0);
      mon_one(1'b1);
      if (fu_en) begin
        g_req.push_back(req_ready[1]);
        g_cyc.push_back(cyc);
      end
    end
  end

  typedef struct {
    bit          r;
    logic [31:0] x;
    logic [31:0] y;
    int          lat;
  } vec_t;
  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lat;
    int r0;
    int g1;
    vecs[0] = '{1'b0, 32'h4080_0000, 32'h4000_0000, 4};
    vecs[1] = '{1'b1, 32'h4110_0000, 32'h4040_0000, 4};
    vecs[2] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 1};
    vecs[3] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1};
    vecs[4] = '{1'b0, 32'h3F80_0000, 32'h3F80_0000, 4};
    vecs[5] = '{1'b1, 32'h4180_0000, 32'h4080_0000, 4};

    // Reset: handshakes gated even with bypassable requests pending
    rstn = 1'b0; req_valid = 2'b11; x0 = '0; x1 = 32'h8000_0000; resp_ready = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_fu_en", 32'(fu_en), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_y", resp_y[31:0] | resp_y[63:32], 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1; req_valid = 2'b00;

    // Single requests: unit latency 4, bypass latency 1
    for (int k = 0; k < 6; k++) begin
      repeat (2) @(posedge clk); #1;
      if (vecs[k].r) x1 = vecs[k].x; else x0 = vecs[k].x;
      req_valid[vecs[k].r] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready[vecs[k].r] && n < 20);
      chk("vec_ready", 32'(req_ready[vecs[k].r]), 32'd1);
      @(posedge clk); #1;
      req_valid = 2'b00;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!resp_valid[vecs[k].r] && lat < 40);
      chk("vec_latency", 32'(lat), 32'(vecs[k].lat));
      chk("vec_y", slot(vecs[k].r), vecs[k].y);
    end

    // Two continuous requesters: alternating grants, 4 cycles apart
    repeat (2) @(posedge clk); #1;
    g_req.delete(); g_cyc.delete();
    x0 = 32'h4080_0000; x1 = 32'h4110_0000; req_valid = 2'b11;
    repeat (17) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("alt_count", 32'(g_req.size() >= 4), 32'd1);
    if (g_req.size() >= 4) begin
      for (int j = 0; j < 4; j++) chk("alt_grant", 32'(g_req[j]), 32'(j % 2));
      for (int j = 0; j < 3; j++) chk("alt_gap", g_cyc[j+1] - g_cyc[j], 32'd4);
    end
    repeat (6) @(posedge clk); #1;

    // Negative-zero bypass while requester 0 is in WAIT
    x0 = 32'h4080_0000; req_valid = 2'b01;
    @(negedge clk);
    chk("wait_grant0", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    x1 = 32'h8000_0000; req_valid = 2'b10;
    @(negedge clk);
    chk("byp_ready1", 32'(req_ready), 32'd2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("byp_valid1", 32'(resp_valid[1]), 32'd1);
    chk("byp_y1", slot(1'b1), 32'h8000_0000);
    repeat (2) @(negedge clk);
    chk("wait_valid0", 32'(resp_valid[0]), 32'd1);
    chk("wait_y0", slot(1'b0), 32'h4000_0000);

    // Full unconsumed slot blocks requester 0 only
    repeat (2) @(posedge clk); #1;
    resp_ready = 2'b10; x0 = '0; req_valid = 2'b01;
    @(negedge clk);
    chk("fill_slot0", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    x0 = 32'h4080_0000; x1 = 32'h4110_0000; req_valid = 2'b11;
    r0 = 0; g1 = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (req_ready[0]) r0++;
      if (req_ready[1]) g1++;
      @(posedge clk); #1;
      if (g1 != 0) req_valid[1] = 1'b0;
    end
    chk("blocked_grants0", 32'(r0), 32'd0);
    chk("served_grants1", 32'(g1), 32'd1);
    resp_ready = 2'b11;
    @(negedge clk);
    chk("unblock_same_cycle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;

    // Timeout: stub never completes, then a normal request with err sticky
    repeat (6) @(posedge clk); #1;
    hold = 1'b1;
    x1 = 32'h4110_0000; req_valid = 2'b10;
    @(negedge clk);
    chk("to_grant", 32'(req_ready), 32'd2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid[1] && lat < 40);
    chk("to_latency", 32'(lat), 32'd16);
    chk("to_y", slot(1'b1), 32'h7FC0_0000);
    chk("to_err", 32'(err), 32'd1);
    @(posedge clk); #1;
    hold = 1'b0;
    x0 = 32'h4080_0000; req_valid = 2'b01;
    @(negedge clk);
    chk("post_to_grant", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid[0] && lat < 40);
    chk("post_to_latency", 32'(lat), 32'd4);
    chk("post_to_y", slot(1'b0), 32'h4000_0000);
    chk("err_sticky", 32'(err), 32'd1);

    // Reset during WAIT drops the result and restarts the pointer
    repeat (2) @(posedge clk); #1;
    x0 = 32'h4080_0000; req_valid = 2'b01;
    @(negedge clk);
    chk("rw_grant0", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    rstn = 1'b0; x1 = '0; req_valid = 2'b10;
    @(negedge clk);
    chk("rw_req_ready", 32'(req_ready), 32'd0);
    chk("rw_fu_en", 32'(fu_en), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1; req_valid = 2'b00;
    @(negedge clk);
    chk("rw_resp_valid", 32'(resp_valid), 32'd0);
    chk("rw_resp_y", resp_y[31:0] | resp_y[63:32], 32'd0);
    chk("rw_err", 32'(err), 32'd0);
    n = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (resp_valid != 2'b00) n++;
    end
    chk("rw_stray_ignored", 32'(n), 32'd0);
    @(posedge clk); #1;
    x0 = 32'h4080_0000; x1 = 32'h4110_0000; req_valid = 2'b11;
    @(negedge clk);
    chk("rw_ptr_restart", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (8) @(posedge clk);

    @(negedge clk);
    chk("sb_drained0", sbq[0].size(), 32'd0);
    chk("sb_drained1", sbq[1].size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
